// File: rtl/retire_trace_buffer.sv
// Retire trace buffer: timestamps each captured retire record and queues it
// in a circular FIFO for a slower consumer behind a valid/ready handshake.
module retire_trace_buffer #(
  parameter int XLEN   = 32,
  parameter int DEPTH  = 16,
  parameter int TS_W   = 32,
  parameter int DROP_W = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     update_i,
  input  logic [XLEN-1:0]          pc_i,
  input  logic [31:0]              instr_i,
  input  logic [4:0]               reg_addr_i,
  input  logic [XLEN-1:0]          reg_data_i,
  input  logic [XLEN-1:0]          mem_addr_i,
  input  logic [XLEN-1:0]          mem_data_i,
  input  logic                     mem_wrt_i,
  input  logic                     enable_i,
  input  logic                     clear_i,
  output logic                     trace_valid_o,
  input  logic                     trace_ready_i,
  output logic [XLEN-1:0]          trace_pc_o,
  output logic [31:0]              trace_instr_o,
  output logic [XLEN-1:0]          trace_rd_data_o,
  output logic [XLEN-1:0]          trace_mem_addr_o,
  output logic [XLEN-1:0]          trace_mem_data_o,
  output logic [4:0]               trace_rd_o,
  output logic                     trace_mem_wrt_o,
  output logic [TS_W-1:0]          trace_ts_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     overflow_o,
  output logic [DROP_W-1:0]        drop_cnt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic [4:0]      rd;
    logic [XLEN-1:0] rd_data;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_data;
    logic            mem_wrt;
    logic [TS_W-1:0] ts;
  } rec_t;

  rec_t              mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [TS_W-1:0]   ts_q, ts_d;
  logic              overflow_q, overflow_d;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
  logic              cap, valid, pop, push, drop;
  rec_t              rec_in, head;

  // Handshake decode, record assembly and next-state computation
  always_comb begin
    cap    = update_i & enable_i;
    valid  = (count_q != {CW{1'b0}});
    pop    = valid & trace_ready_i;
    push   = cap & ((count_q != FULL_CNT) | pop);
    drop   = cap & ~push;

    rec_in.pc       = pc_i;
    rec_in.instr    = instr_i;
    rec_in.rd       = reg_addr_i;
    rec_in.rd_data  = (reg_addr_i == 5'd0) ? {XLEN{1'b0}} : reg_data_i;
    rec_in.mem_addr = mem_addr_i;
    rec_in.mem_data = mem_data_i;
    rec_in.mem_wrt  = mem_wrt_i;
    rec_in.ts       = ts_q;

    ts_d       = ts_q + TS_W'(1);
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;

    // Clear outranks everything except the free-running timestamp
    if (clear_i) begin
      wr_ptr_d   = {AW{1'b0}};
      rd_ptr_d   = {AW{1'b0}};
      count_d    = {CW{1'b0}};
      overflow_d = 1'b0;
      drop_cnt_d = {DROP_W{1'b0}};
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      else      wr_ptr_d = wr_ptr_q;
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      else      rd_ptr_d = rd_ptr_q;
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      if (drop) begin
        overflow_d = 1'b1;
        if (drop_cnt_q != {DROP_W{1'b1}}) drop_cnt_d = drop_cnt_q + DROP_W'(1);
        else                              drop_cnt_d = drop_cnt_q;
      end else begin
        overflow_d = overflow_q;
      end
    end
  end

  // Control and status state registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q   <= {AW{1'b0}};
      rd_ptr_q   <= {AW{1'b0}};
      count_q    <= {CW{1'b0}};
      ts_q       <= {TS_W{1'b0}};
      overflow_q <= 1'b0;
      drop_cnt_q <= {DROP_W{1'b0}};
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ts_q       <= ts_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Record storage; contents are meaningless whenever the FIFO is empty
  always_ff @(posedge clk_i) begin
    if (push & ~clear_i & ~rst_i) begin
      mem_q[wr_ptr_q] <= rec_in;
    end
  end

  // Outputs are forced to zero when empty so reset and drained states read clean
  always_comb begin
    if (valid) head = mem_q[rd_ptr_q];
    else       head = '0;
  end

  assign trace_valid_o    = valid;
  assign trace_pc_o       = head.pc;
  assign trace_instr_o    = head.instr;
  assign trace_rd_o       = head.rd;
  assign trace_rd_data_o  = head.rd_data;
  assign trace_mem_addr_o = head.mem_addr;
  assign trace_mem_data_o = head.mem_data;
  assign trace_mem_wrt_o  = head.mem_wrt;
  assign trace_ts_o       = head.ts;
  assign count_o          = count_q;
  assign overflow_o       = overflow_q;
  assign drop_cnt_o       = drop_cnt_q;

endmodule

// File: tb/tb_retire_trace_buffer.sv
// Scenario bench for retire_trace_buffer: expected records are queued when
// captures are driven and compared as the consumer pops them.
module tb_retire_trace_buffer;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  rd;
    logic [31:0] rd_data;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic        mem_wrt;
    logic [31:0] ts;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        update_i = 1'b0, enable_i = 1'b0, clear_i = 1'b0, trace_ready_i = 1'b0;
  logic [31:0] pc_i = '0, instr_i = '0, reg_data_i = '0, mem_addr_i = '0, mem_data_i = '0;
  logic [4:0]  reg_addr_i = '0;
  logic        mem_wrt_i = 1'b0;
  logic        trace_valid_o, trace_mem_wrt_o, overflow_o;
  logic [31:0] trace_pc_o, trace_instr_o, trace_rd_data_o, trace_mem_addr_o, trace_mem_data_o;
  logic [31:0] trace_ts_o;
  logic [4:0]  trace_rd_o;
  logic [4:0]  count_o;
  logic [15:0] drop_cnt_o;

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [31:0] tb_ts = '0;
  rec_t        exp_q[$];

  retire_trace_buffer dut (
    .clk_i(clk), .rst_i(rst_i), .update_i(update_i), .pc_i(pc_i), .instr_i(instr_i),
    .reg_addr_i(reg_addr_i), .reg_data_i(reg_data_i), .mem_addr_i(mem_addr_i),
    .mem_data_i(mem_data_i), .mem_wrt_i(mem_wrt_i), .enable_i(enable_i), .clear_i(clear_i),
    .trace_valid_o(trace_valid_o), .trace_ready_i(trace_ready_i), .trace_pc_o(trace_pc_o),
    .trace_instr_o(trace_instr_o), .trace_rd_data_o(trace_rd_data_o),
    .trace_mem_addr_o(trace_mem_addr_o), .trace_mem_data_o(trace_mem_data_o),
    .trace_rd_o(trace_rd_o), .trace_mem_wrt_o(trace_mem_wrt_o), .trace_ts_o(trace_ts_o),
    .count_o(count_o), .overflow_o(overflow_o), .drop_cnt_o(drop_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    tb_ts = tb_ts + 32'd1;
  endtask

  task automatic do_reset();
    update_i = 1'b0; enable_i = 1'b0; clear_i = 1'b0; trace_ready_i = 1'b0;
    rst_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_i = 1'b0;
    tb_ts = '0;
    exp_q.delete();
  endtask

  function automatic rec_t rand_rec(input logic [31:0] pc);
    rec_t r;
    r.pc = pc; r.instr = $urandom; r.rd = 5'($urandom_range(1, 31));
    r.rd_data = $urandom; r.mem_addr = $urandom; r.mem_data = $urandom;
    r.mem_wrt = 1'($urandom_range(0, 1)); r.ts = '0;
    return r;
  endfunction

  // Expected stored form: x0 writes carry no data, timestamp is the capture cycle
  function automatic rec_t expect_of(input rec_t r);
    rec_t e = r;
    if (e.rd == 5'd0) e.rd_data = '0;
    e.ts = tb_ts;
    return e;
  endfunction

  task automatic drive(input rec_t r);
    update_i = 1'b1; enable_i = 1'b1;
    pc_i = r.pc; instr_i = r.instr; reg_addr_i = r.rd; reg_data_i = r.rd_data;
    mem_addr_i = r.mem_addr; mem_data_i = r.mem_data; mem_wrt_i = r.mem_wrt;
  endtask

  function automatic rec_t got_rec();
    rec_t g;
    g.pc = trace_pc_o; g.instr = trace_instr_o; g.rd = trace_rd_o;
    g.rd_data = trace_rd_data_o; g.mem_addr = trace_mem_addr_o; g.mem_data = trace_mem_data_o;
    g.mem_wrt = trace_mem_wrt_o; g.ts = trace_ts_o;
    return g;
  endfunction

  task automatic test_reset();
    rec_t r, e;
    do_reset();
    checks++; if (trace_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", trace_valid_o); end
    checks++; if (count_o !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d exp 0", count_o); end
    checks++; if (drop_cnt_o !== 16'd0 || overflow_o !== 1'b0) begin errors++; $display("FAIL reset_drop: got %0d/%b exp 0/0", drop_cnt_o, overflow_o); end
    checks++; if (got_rec() !== '0) begin errors++; $display("FAIL reset_fields: got %h exp 0", got_rec()); end
    // Capture in the very first cycle after release must be stamped 0
    r = rand_rec(32'h0000_0200); e = expect_of(r); drive(r); tick();
    drive(rand_rec(32'h0000_0204)); tick();
    update_i = 1'b0;
    checks++; if (got_rec() !== e) begin errors++; $display("FAIL reset_first_ts: got %h exp %h", got_rec(), e); end
    checks++; if (count_o !== 5'd2) begin errors++; $display("FAIL pre_rst_count: got %0d exp 2", count_o); end
    do_reset();
    checks++; if (trace_valid_o !== 1'b0 || count_o !== 5'd0 || got_rec() !== '0) begin errors++; $display("FAIL midstream_reset: got v=%b c=%0d pc=%h exp 0/0/0", trace_valid_o, count_o, trace_pc_o); end
  endtask

  task automatic test_single();
    rec_t r;
    repeat (3) tick();
    r.pc = 32'h10; r.instr = 32'h0050_0093; r.rd = 5'd1; r.rd_data = 32'd5;
    r.mem_addr = '0; r.mem_data = '0; r.mem_wrt = 1'b0; r.ts = '0;
    exp_q.push_back(expect_of(r));
    drive(r); tick(); update_i = 1'b0;
    checks++; if (trace_valid_o !== 1'b1) begin errors++; $display("FAIL single_valid: got %b exp 1", trace_valid_o); end
    checks++; if (trace_ts_o !== 32'd3) begin errors++; $display("FAIL single_ts: got %0d exp 3", trace_ts_o); end
    checks++; if (got_rec() !== exp_q[0]) begin errors++; $display("FAIL single_rec: got %h exp %h", got_rec(), exp_q[0]); end
    trace_ready_i = 1'b1; void'(exp_q.pop_front()); tick(); trace_ready_i = 1'b0;
    checks++; if (count_o !== 5'd0 || trace_valid_o !== 1'b0) begin errors++; $display("FAIL single_pop: got c=%0d v=%b exp 0/0", count_o, trace_valid_o); end
  endtask

  task automatic test_overflow();
    rec_t r;
    trace_ready_i = 1'b0;
    for (int i = 0; i < 17; i++) begin
      r = rand_rec(32'(i * 4));
      if (i == 0) r.rd = 5'd0;
      if (i < 16) exp_q.push_back(expect_of(r));
      drive(r); tick();
      // Head must hold steady while the consumer stalls
      checks++; if (got_rec() !== exp_q[0]) begin errors++; $display("FAIL ovf_hold[%0d]: got %h exp %h", i, got_rec(), exp_q[0]); end
    end
    update_i = 1'b0;
    checks++; if (count_o !== 5'd16) begin errors++; $display("FAIL ovf_count: got %0d exp 16", count_o); end
    checks++; if (overflow_o !== 1'b1 || drop_cnt_o !== 16'd1) begin errors++; $display("FAIL ovf_drop: got %b/%0d exp 1/1", overflow_o, drop_cnt_o); end
  endtask

  task automatic test_drain(input int n_expect);
    int n = 0;
    update_i = 1'b0; trace_ready_i = 1'b1;
    for (int c = 0; c < 24; c++) begin
      if (!trace_valid_o) break;
      checks++;
      if (exp_q.size() == 0) begin errors++; $display("FAIL drain_extra: got pc %h exp none", trace_pc_o); end
      else if (got_rec() !== exp_q[0]) begin errors++; $display("FAIL drain_rec[%0d]: got %h exp %h", n, got_rec(), exp_q[0]); end
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      n++;
      tick();
    end
    trace_ready_i = 1'b0;
    checks++; if (n != n_expect) begin errors++; $display("FAIL drain_len: got %0d exp %0d", n, n_expect); end
    checks++; if (trace_valid_o !== 1'b0 || count_o !== 5'd0) begin errors++; $display("FAIL drain_empty: got v=%b c=%0d exp 0/0", trace_valid_o, count_o); end
  endtask

  task automatic test_full_push_pop();
    rec_t r;
    trace_ready_i = 1'b0;
    for (int i = 0; i < 16; i++) begin
      r = rand_rec(32'h100 + 32'(i * 4)); exp_q.push_back(expect_of(r)); drive(r); tick();
    end
    checks++; if (count_o !== 5'd16) begin errors++; $display("FAIL full_fill: got %0d exp 16", count_o); end
    trace_ready_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      checks++; if (got_rec() !== exp_q[0]) begin errors++; $display("FAIL full_pp_rec[%0d]: got %h exp %h", i, got_rec(), exp_q[0]); end
      void'(exp_q.pop_front());
      r = rand_rec(32'h200 + 32'(i * 4)); exp_q.push_back(expect_of(r)); drive(r); tick();
      checks++; if (count_o !== 5'd16) begin errors++; $display("FAIL full_pp_count[%0d]: got %0d exp 16", i, count_o); end
    end
    update_i = 1'b0; trace_ready_i = 1'b0;
    checks++; if (drop_cnt_o !== 16'd1 || overflow_o !== 1'b1) begin errors++; $display("FAIL full_pp_drop: got %0d/%b exp 1/1", drop_cnt_o, overflow_o); end
  endtask

  task automatic test_clear();
    rec_t r, e;
    trace_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      r = rand_rec(32'h300 + 32'(i * 4)); exp_q.push_back(expect_of(r)); drive(r); tick();
    end
    checks++; if (count_o !== 5'd5 || overflow_o !== 1'b1) begin errors++; $display("FAIL clr_pre: got c=%0d o=%b exp 5/1", count_o, overflow_o); end
    clear_i = 1'b1; trace_ready_i = 1'b1; drive(rand_rec(32'h400)); tick();
    clear_i = 1'b0; trace_ready_i = 1'b0; update_i = 1'b0; exp_q.delete();
    checks++; if (count_o !== 5'd0 || trace_valid_o !== 1'b0) begin errors++; $display("FAIL clr_empty: got c=%0d v=%b exp 0/0", count_o, trace_valid_o); end
    checks++; if (overflow_o !== 1'b0 || drop_cnt_o !== 16'd0) begin errors++; $display("FAIL clr_drop: got %b/%0d exp 0/0", overflow_o, drop_cnt_o); end
    // Timestamp keeps running straight through a clear
    r = rand_rec(32'h500); e = expect_of(r); drive(r); tick(); update_i = 1'b0;
    checks++; if (got_rec() !== e) begin errors++; $display("FAIL clr_ts: got %h exp %h", got_rec(), e); end
    trace_ready_i = 1'b1; tick(); trace_ready_i = 1'b0;
  endtask

  task automatic test_filter();
    rec_t r, e;
    r = rand_rec(32'h600); r.rd = 5'd0; r.rd_data = 32'h0000_DEAD;
    e = expect_of(r); drive(r); tick(); update_i = 1'b0;
    checks++; if (trace_rd_data_o !== 32'd0) begin errors++; $display("FAIL filt_x0: got %h exp 0", trace_rd_data_o); end
    checks++; if (got_rec() !== e) begin errors++; $display("FAIL filt_rec: got %h exp %h", got_rec(), e); end
    trace_ready_i = 1'b1; tick(); trace_ready_i = 1'b0;
    drive(rand_rec(32'h700)); enable_i = 1'b0;
    repeat (3) tick();
    update_i = 1'b0;
    checks++; if (count_o !== 5'd0 || drop_cnt_o !== 16'd0 || overflow_o !== 1'b0) begin errors++; $display("FAIL filt_disabled: got c=%0d d=%0d o=%b exp 0/0/0", count_o, drop_cnt_o, overflow_o); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_drain(16);
    test_full_push_pop();
    test_drain(16);
    test_clear();
    test_filter();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/retire_trace_buffer.md
# retire_trace_buffer

Captures the per-instruction retire records emitted by the pipelined RV32I core's retire interface, timestamps each one, and queues them in a FIFO for a slower trace consumer (testbench scoreboard, UART dumper, or logic analyzer bridge) behind a valid/ready handshake. It is the receiving end of the core's retire port: the core produces one record per retire cycle with no back-pressure, and this block absorbs bursts, reports drops and exposes occupancy.

## Interface
- XLEN, 32, data/address width of retire fields
- DEPTH, 16, FIFO entries; power of two, ≥2
- TS_W, 32, timestamp width
- DROP_W, 16, drop counter width
- clk_i  in  1  system clock, all logic on rising edge
- rst_i  in  1  synchronous, active-high reset
- update_i  in  1  retire qualifier; one record per cycle sampled high
- pc_i  in  XLEN  retired PC
- instr_i  in  32  retired instruction
- reg_addr_i  in  5  destination register
- reg_data_i  in  XLEN  register write data
- mem_addr_i  in  XLEN  data memory address
- mem_data_i  in  XLEN  data memory write data
- mem_wrt_i  in  1  memory write flag
- enable_i  in  1  capture enable
- clear_i  in  1  flush FIFO, clear drop state
- trace_valid_o  out  1  head record available
- trace_ready_i  in  1  consumer accepts head record
- trace_pc_o, trace_instr_o, trace_rd_data_o, trace_mem_addr_o, trace_mem_data_o  out  XLEN/32  head record fields
- trace_rd_o  out  5  head record rd
- trace_mem_wrt_o  out  1  head record memory write flag
- trace_ts_o  out  TS_W  head record timestamp
- count_o  out  log2(DEPTH)+1  occupancy
- overflow_o  out  1  sticky: at least one record dropped
- drop_cnt_o  out  DROP_W  dropped records, saturating

## Operation
- Timestamp counter ts: 0 at reset, +1 every cycle regardless of enable_i/clear_i, wraps modulo 2^TS_W.
- Capture request cap = update_i & enable_i. Record = {pc, instr, rd, rd_data, mem_addr, mem_data, mem_wrt, ts of capture cycle}.
- rd_data stored as 0 when reg_addr_i == 0 (x0 writes carry no data).
- pop = trace_valid_o & trace_ready_i.
- push = cap & (count < DEPTH | pop). Push while full is accepted only when a pop occurs in the same cycle.
- cap & !push → drop: overflow_o ← 1, drop_cnt_o += 1, saturating at 2^DROP_W−1.
- update_i with enable_i = 0 is ignored: not stored, not counted as a drop.
- FIFO: circular buffer, write/read pointers wrap at DEPTH; count += push − pop.
- Output fields show the head entry whenever trace_valid_o = 1; they must not change while valid & !ready.
- clear_i: highest priority; empties FIFO (pointers and count to 0), clears overflow_o and drop_cnt_o; a same-cycle capture and pop are discarded; ts unaffected.
- Record order is strictly preserved; no reordering or merging.

## Timing
- Reset values: trace_valid_o 0, count_o 0, overflow_o 0, drop_cnt_o 0, ts 0, all trace data outputs 0.
- Capture-to-valid latency: 1 cycle (record pushed at edge N is visible after edge N; no combinational bypass from update_i to outputs).
- trace_valid_o = (count ≠ 0), registered state only; trace_ready_i has no combinational path to trace_valid_o.
- Pop at edge N: next head (if any) presented after edge N; back-to-back pops sustain 1 record/cycle.
- Push and pop in the same cycle with FIFO empty: not possible (valid = 0); push only.
- Full + push + pop: count stays DEPTH, no drop.
- rst_i asserted mid-stream: all contents lost, outputs return to reset values on the next edge.

## Test plan
- Reset: hold rst_i 3 cycles → trace_valid_o 0, count_o 0, drop_cnt_o 0; ts 0 on first cycle after release.
- Single record: at ts=3 drive update_i=1, pc 0x10, instr 0x00500093, rd 1, data 5 → next cycle valid 1, fields match, trace_ts_o 3; ready=1 → count_o 0, valid 0.
- Overflow: ready=0, 17 consecutive captures (DEPTH 16) → count_o 16, overflow_o 1, drop_cnt_o 1; drain with ready=1 returns pcs 0x0..0x3C in order, 16 records, then valid 0.
- Full with simultaneous push/pop: FIFO full, capture and ready=1 every cycle for 10 cycles → count_o stays 16, drop_cnt_o unchanged.
- Clear priority: 5 records queued, clear_i=1 together with capture and ready=1 → next cycle count_o 0, valid 0, overflow_o 0, drop_cnt_o 0.
- Filtering: capture rd 0 with reg_data 0xDEAD → trace_rd_data_o 0; update_i=1 with enable_i=0 → count_o and drop_cnt_o unchanged.
